// File: rtl/mc_control_if.sv
// mc_control_if: bundles the opcode/handshake inputs and the datapath
// control outputs of the multicycle main control unit.
// The controller uses the master modport; the datapath side uses slave.
interface mc_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [1:0] aluop;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output aluop, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
           i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, instr_done, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  aluop, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
           i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
           reg_write, instr_done, illegal_op, state
  );
endinterface

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS32 main control FSM. Sequences lw, sw,
// R-format, beq and j over 3-5 cycles, stalling on mem_ready in FETCH,
// MEM_READ and MEM_WRITE.
// Optional feature: define MC_CONTROL_ADDI_EN to build the addi path
// (ADDI_EXEC/ADDI_WB); otherwise opcode 001000 is reported as illegal.
module mc_control (
  input  logic         clk,
  input  logic         rst_n,
  mc_control_if.master ctl
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e state_q, state_d;

  // Next-state selection; unused encodings fall back to FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (ctl.mem_ready) state_d = DECODE;
      DECODE: begin
        case (ctl.opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      state_d = ADDI_EXEC;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEM_ADDR:  state_d = (ctl.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (ctl.mem_ready) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: if (ctl.mem_ready) state_d = FETCH;
      EXECUTE:   state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JUMP:      state_d = FETCH;
`ifdef MC_CONTROL_ADDI_EN
      ADDI_EXEC: state_d = ADDI_WB;
      ADDI_WB:   state_d = FETCH;
`endif
      default:   state_d = FETCH;
    endcase
  end

  // State register; reset returns to FETCH without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Datapath controls decoded from the current state; everything is held
  // at zero while reset is asserted so no write can slip out.
  always_comb begin
    ctl.aluop         = 2'b00;
    ctl.alu_src_a     = 1'b0;
    ctl.alu_src_b     = 2'b00;
    ctl.pc_source     = 2'b00;
    ctl.pc_write      = 1'b0;
    ctl.pc_write_cond = 1'b0;
    ctl.i_or_d        = 1'b0;
    ctl.mem_read      = 1'b0;
    ctl.mem_write     = 1'b0;
    ctl.ir_write      = 1'b0;
    ctl.mem_to_reg    = 1'b0;
    ctl.reg_dst       = 1'b0;
    ctl.reg_write     = 1'b0;
    ctl.instr_done    = 1'b0;
    ctl.illegal_op    = 1'b0;
    ctl.state         = 4'd0;
    if (rst_n) begin
      ctl.state = state_q;
      case (state_q)
        FETCH: begin
          ctl.mem_read  = 1'b1;
          ctl.alu_src_b = 2'b01;
          ctl.ir_write  = ctl.mem_ready;
          ctl.pc_write  = ctl.mem_ready;
        end
        DECODE: begin
          ctl.alu_src_b = 2'b11;
          case (ctl.opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: ctl.illegal_op = 1'b0;
`ifdef MC_CONTROL_ADDI_EN
            OP_ADDI: ctl.illegal_op = 1'b0;
`endif
            default: ctl.illegal_op = 1'b1;
          endcase
        end
        MEM_ADDR: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = 2'b10;
        end
        MEM_READ: begin
          ctl.mem_read = 1'b1;
          ctl.i_or_d   = 1'b1;
        end
        MEM_WB: begin
          ctl.reg_write  = 1'b1;
          ctl.mem_to_reg = 1'b1;
          ctl.instr_done = 1'b1;
        end
        MEM_WRITE: begin
          ctl.mem_write  = 1'b1;
          ctl.i_or_d     = 1'b1;
          ctl.instr_done = ctl.mem_ready;
        end
        EXECUTE: begin
          ctl.alu_src_a = 1'b1;
          ctl.aluop     = 2'b10;
        end
        R_WB: begin
          ctl.reg_dst    = 1'b1;
          ctl.reg_write  = 1'b1;
          ctl.instr_done = 1'b1;
        end
        BRANCH: begin
          ctl.alu_src_a     = 1'b1;
          ctl.aluop         = 2'b01;
          ctl.pc_write_cond = 1'b1;
          ctl.pc_source     = 2'b01;
          ctl.instr_done    = 1'b1;
        end
        JUMP: begin
          ctl.pc_write   = 1'b1;
          ctl.pc_source  = 2'b10;
          ctl.instr_done = 1'b1;
        end
`ifdef MC_CONTROL_ADDI_EN
        ADDI_EXEC: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = 2'b10;
        end
        ADDI_WB: begin
          ctl.reg_write  = 1'b1;
          ctl.instr_done = 1'b1;
        end
`endif
        default: ctl.state = state_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed testbench for mc_control. Each instruction is
// described by its opcode and stall counts; the expected per-cycle control
// vectors are built from the instruction's phase list and compared every
// cycle by a single compare process.
module tb_mc_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mc_control_if bus ();

  mc_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic [1:0] aluop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  ctl_t act;
  assign act = {bus.state, bus.aluop, bus.alu_src_a, bus.alu_src_b, bus.pc_source,
                bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                bus.reg_write, bus.instr_done, bus.illegal_op};

  ctl_t exp_q[$];
  ctl_t exp_now;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_run = 0;
  int   last_len = 0;
  int   end_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic ctl_t idle(input logic [3:0] st);
    ctl_t e;
    e = '0;
    e.state = st;
    return e;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010: return 1'b1;
`ifdef MC_CONTROL_ADDI_EN
      6'b001000: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Compare process: on every falling edge, measure instruction length
  // from the DUT's end pulses and check the queued expectation, if any.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc_run++;
      if (act.instr_done || act.illegal_op) begin
        last_len = cyc_run;
        cyc_run  = 0;
        end_cnt++;
      end
    end else begin
      cyc_run = 0;
    end
    if (exp_q.size() > 0) begin
      exp_now = exp_q.pop_front();
      checkOutput($sformatf("cycle state %0d", exp_now.state), 32'(act), 32'(exp_now));
    end
  end

  // One clock cycle: drive mem_ready, queue that cycle's expectation.
  task automatic step(input logic rdy, input ctl_t e);
    bus.mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Run one whole instruction with the given stall counts and check its
  // length (measured from DUT pulses) against a hand-computed value.
  task automatic applyStimulus(input string name, input logic [5:0] op,
                               input int fstall, input int mstall, input int exp_len);
    ctl_t e;
    int   ends0;
    ends0 = end_cnt;
    bus.opcode = op;
    for (int i = 0; i < fstall; i++) begin
      e = idle(4'd0); e.mem_read = 1'b1; e.alu_src_b = 2'b01;
      step(1'b0, e);
    end
    e = idle(4'd0); e.mem_read = 1'b1; e.alu_src_b = 2'b01;
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    step(1'b1, e);
    e = idle(4'd1); e.alu_src_b = 2'b11; e.illegal_op = !is_legal(op);
    step(1'b1, e);
    if (is_legal(op)) begin
      case (op)
        6'b100011, 6'b101011: begin
          e = idle(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
          step(1'b1, e);
          if (op == 6'b100011) begin
            e = idle(4'd3); e.mem_read = 1'b1; e.i_or_d = 1'b1;
            for (int i = 0; i < mstall; i++) step(1'b0, e);
            step(1'b1, e);
            e = idle(4'd4); e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
            step(1'b1, e);
          end else begin
            e = idle(4'd5); e.mem_write = 1'b1; e.i_or_d = 1'b1;
            for (int i = 0; i < mstall; i++) step(1'b0, e);
            e.instr_done = 1'b1;
            step(1'b1, e);
          end
        end
        6'b000000: begin
          e = idle(4'd6); e.alu_src_a = 1'b1; e.aluop = 2'b10;
          step(1'b1, e);
          e = idle(4'd7); e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
          step(1'b1, e);
        end
        6'b000100: begin
          e = idle(4'd8); e.alu_src_a = 1'b1; e.aluop = 2'b01;
          e.pc_write_cond = 1'b1; e.pc_source = 2'b01; e.instr_done = 1'b1;
          step(1'b1, e);
        end
        6'b000010: begin
          e = idle(4'd9); e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1;
          step(1'b1, e);
        end
        default: begin
          e = idle(4'd10); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
          step(1'b1, e);
          e = idle(4'd11); e.reg_write = 1'b1; e.instr_done = 1'b1;
          step(1'b1, e);
        end
      endcase
    end
    checkOutput({name, " length"}, last_len, exp_len);
    checkOutput({name, " end pulses"}, end_cnt - ends0, 1);
  endtask

  // Main stimulus sequence.
  initial begin
    bus.opcode    = 6'd0;
    bus.mem_ready = 1'b0;
    #2;
    checkOutput("reset outputs", 32'(act), 32'd0);
    @(negedge clk);
    checkOutput("reset hold", 32'(act), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus("lw", 6'b100011, 0, 0, 5);
    applyStimulus("rtype", 6'b000000, 0, 0, 4);
    applyStimulus("beq", 6'b000100, 0, 0, 3);
    applyStimulus("j", 6'b000010, 0, 0, 3);
    applyStimulus("sw stall2", 6'b101011, 0, 2, 6);
    applyStimulus("lw stalls", 6'b100011, 1, 1, 7);
`ifdef MC_CONTROL_ADDI_EN
    applyStimulus("addi", 6'b001000, 0, 0, 4);
`else
    applyStimulus("addi illegal", 6'b001000, 0, 0, 2);
`endif
    applyStimulus("illegal 111111", 6'b111111, 0, 0, 2);

    // Reset in the middle of an R-format instruction.
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("execute state", 32'(bus.state), 32'd6);
    checkOutput("execute aluop", 32'(bus.aluop), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset", 32'(act), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset held", 32'(act), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("post-reset fetch", 32'({bus.state, bus.mem_read, bus.reg_write}), 32'({4'd0, 1'b1, 1'b0}));
    #2;
    applyStimulus("j after reset", 6'b000010, 0, 0, 3);

    checkOutput("queue drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control unit for the MIPS32 core: a state machine that decodes the instruction opcode and sequences one instruction over 3–5 cycles. It drives datapath mux selects and write enables, plus the 2-bit `aluop` consumed directly by the downstream ALU-control decoder (00 add, 01 subtract, 10 R-format by funct). It also stalls on a memory-ready handshake.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- opcode  in  6  IR[31:26]; stable from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- aluop  out  2  to ALU control: 00 add, 01 sub, 10 R-format
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write  out  1 each  datapath controls
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state encoding, for debug

## Operation
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11. Codes 12–15 are unused; if reached, go to FETCH.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, alu_src_b=01, aluop=00.
  - When mem_ready=1: ir_write=1 and pc_write=1, then go to DECODE.
  - When mem_ready=0: hold in FETCH.
- DECODE:
  - Outputs: alu_src_b=11, aluop=00.
  - Next state by opcode: 100011 (lw) / 101011 (sw) → MEM_ADDR; 000000 → EXECUTE; 000100 → BRANCH; 000010 → JUMP; 001000 → ADDI_EXEC (macro only).
  - Any other opcode: illegal_op=1, next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, aluop=00. Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Hold in MEM_READ until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next: FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready=1. In the mem_ready cycle: instr_done=1, next FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, aluop=10. Next: R_WB.
- R_WB: reg_dst=1, reg_write=1, instr_done=1. Next: FETCH.
- BRANCH: alu_src_a=1, aluop=01, pc_write_cond=1, pc_source=01, instr_done=1. Next: FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next: FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, aluop=00. Next: ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next: FETCH.

## Timing
- Reset:
  - rst_n low sets state to FETCH immediately, without waiting for a clock edge.
  - While rst_n is low, every output is forced to 0, including aluop=00 and state=0.
  - Reset asserted mid-instruction abandons that instruction. No write enable is asserted while reset is held.
- Outputs decode combinationally from the registered state. The exceptions are the mem_ready-gated ir_write, pc_write (FETCH) and instr_done (MEM_WRITE).
- Cycle counts with mem_ready held at 1:
  - lw: 5
  - sw: 4
  - R-format: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. mem_read and mem_write stay asserted for the whole stall.
- The beq outcome is resolved in the datapath (pc_write_cond AND zero). The controller always spends 3 cycles on beq.

## Configuration
- `MC_CONTROL_ADDI_EN` defined: opcode 001000 goes DECODE → ADDI_EXEC → ADDI_WB.
- `MC_CONTROL_ADDI_EN` undefined:
  - ADDI states are not built.
  - Opcode 001000 is illegal: illegal_op pulses and the controller returns to FETCH.
  - Codes 10–11 are treated as unused.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-EXECUTE → state=0 and all outputs 0 asynchronously; after release, FETCH with mem_read=1.
- lw, opcode 100011, mem_ready=1 → state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 in cycle 5. instr_done pulses exactly once.
- R-format, opcode 000000 → aluop=10 in EXECUTE. reg_dst=1 and reg_write=1 in R_WB. 4 cycles total.
- beq, opcode 000100 → aluop=01, pc_write_cond=1, pc_source=01 in cycle 3. Then j, opcode 000010 → pc_write=1, pc_source=10.
- sw with mem_ready=0 for 2 cycles in MEM_WRITE → mem_write held high 3 cycles, 6 cycles total. instr_done only in the mem_ready cycle.
- Opcode 001000:
  - With `MC_CONTROL_ADDI_EN`: reg_write in cycle 4, no illegal_op.
  - Without it: illegal_op=1 in DECODE, back to FETCH in cycle 3.
